// File: rtl/door_controller.sv
// Car-door sequencer: open/dwell/close, overload hold, weight-counter clear, motion gating.
// Optional door-edge obstruction input enabled by defining DOOR_OBSTRUCTION_EN.
module door_controller #(
  parameter int OPEN_CYCLES    = 50_000_000,
  parameter int TRANSIT_CYCLES = 10_000_000,
  parameter int TIMER_W        = 32
) (
  input  logic       clk,
  input  logic       button_reset,
  input  logic       arrived,
  input  logic       open_request,
  input  logic       close_request,
  input  logic       load_clear,
  input  logic       weight_limit_exceeded,
`ifdef DOOR_OBSTRUCTION_EN
  input  logic       obstruction,
`endif
  output logic       door,
  output logic       weight_flip_reset,
  output logic       motion_enable,
  output logic       overload_alarm,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_CLOSED   = 3'd0,
    S_OPENING  = 3'd1,
    S_OPEN     = 3'd2,
    S_CLOSING  = 3'd3,
    S_OVERLOAD = 3'd4,
    S_CLEARING = 3'd5
  } state_t;

  localparam logic [TIMER_W-1:0] L_OPEN  = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] L_TRANS = TIMER_W'(TRANSIT_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   w_timer_nxt;
  logic [1:0]           r_sync;
  logic                 w_wle_s;
  logic                 w_obs;
  logic                 w_tz;

  assign w_wle_s = r_sync[1];
  assign w_tz    = (r_timer == '0);

`ifdef DOOR_OBSTRUCTION_EN
  assign w_obs = obstruction;
`else
  assign w_obs = 1'b0;
`endif

  always_ff @(posedge clk or posedge button_reset) begin
    if (button_reset) begin
      r_state <= S_CLOSED;
      r_timer <= '0;
      r_sync  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_sync  <= {r_sync[0], weight_limit_exceeded};
    end
  end

  // Timer saturates at zero; transitions below override with a fresh load
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = w_tz ? r_timer : r_timer - 1'b1;
    case (r_state)
      S_CLOSED: begin
        if (arrived || open_request) begin
          w_state_nxt = S_OPENING;
          w_timer_nxt = L_TRANS;
        end
      end
      S_OPENING: begin
        if (w_tz) begin
          if (w_wle_s) begin
            w_state_nxt = S_OVERLOAD;
          end else begin
            w_state_nxt = S_OPEN;
            w_timer_nxt = L_OPEN;
          end
        end
      end
      S_OPEN: begin
        if (w_wle_s) begin
          w_state_nxt = S_OVERLOAD;
        end else if (open_request) begin
          w_timer_nxt = L_OPEN;
        end else if (close_request && !w_obs) begin
          w_state_nxt = S_CLOSING;
          w_timer_nxt = L_TRANS;
        end else if (w_tz) begin
          if (w_obs) begin
            w_timer_nxt = L_OPEN;
          end else begin
            w_state_nxt = S_CLOSING;
            w_timer_nxt = L_TRANS;
          end
        end
      end
      S_CLOSING: begin
        if (w_wle_s || open_request || w_obs) begin
          w_state_nxt = S_OPENING;
          w_timer_nxt = L_TRANS;
        end else if (w_tz) begin
          w_state_nxt = S_CLOSED;
        end
      end
      S_OVERLOAD: begin
        w_timer_nxt = r_timer;
        if (load_clear) w_state_nxt = S_CLEARING;
      end
      S_CLEARING: begin
        w_timer_nxt = r_timer;
        if (!w_wle_s) begin
          w_state_nxt = S_OPEN;
          w_timer_nxt = L_OPEN;
        end
      end
      default: begin
        w_state_nxt = S_CLOSED;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign door              = (r_state != S_CLOSED);
  assign weight_flip_reset = (r_state == S_CLEARING);
  assign motion_enable     = (r_state == S_CLOSED);
  assign overload_alarm    = (r_state == S_OVERLOAD) || (r_state == S_CLEARING);
  assign state             = r_state;

endmodule

// File: tb/tb_door_controller.sv
// Directed bench for door_controller with OPEN_CYCLES=8, TRANSIT_CYCLES=4.
// Timing expectations are hand-counted in clock edges from each stimulus.
module tb_door_controller;

  logic       clk = 1'b0;
  logic       button_reset;
  logic       arrived;
  logic       open_request;
  logic       close_request;
  logic       load_clear;
  logic       weight_limit_exceeded;
`ifdef DOOR_OBSTRUCTION_EN
  logic       obstruction;
`endif
  logic       door;
  logic       weight_flip_reset;
  logic       motion_enable;
  logic       overload_alarm;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  door_controller #(
    .OPEN_CYCLES   (8),
    .TRANSIT_CYCLES(4),
    .TIMER_W       (32)
  ) dut (
    .clk                  (clk),
    .button_reset         (button_reset),
    .arrived              (arrived),
    .open_request         (open_request),
    .close_request        (close_request),
    .load_clear           (load_clear),
    .weight_limit_exceeded(weight_limit_exceeded),
`ifdef DOOR_OBSTRUCTION_EN
    .obstruction          (obstruction),
`endif
    .door                 (door),
    .weight_flip_reset    (weight_flip_reset),
    .motion_enable        (motion_enable),
    .overload_alarm       (overload_alarm),
    .state                (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arrive_to_open();
    arrived = 1'b1;
    step(1);
    arrived = 1'b0;
    step(4);
  endtask

  int n;

  initial begin
    button_reset          = 1'b1;
    arrived               = 1'b0;
    open_request          = 1'b0;
    close_request         = 1'b0;
    load_clear            = 1'b0;
    weight_limit_exceeded = 1'b0;
`ifdef DOOR_OBSTRUCTION_EN
    obstruction           = 1'b0;
`endif
    #3;
    chk("rst_state", 32'(state), 0);
    chk("rst_door", 32'(door), 0);
    chk("rst_me", 32'(motion_enable), 1);
    chk("rst_alarm", 32'(overload_alarm), 0);
    chk("rst_wfr", 32'(weight_flip_reset), 0);
    #20;
    @(negedge clk);
    button_reset = 1'b0;
    step(1);

    // normal cycle
    arrived = 1'b1;
    step(1);
    arrived = 1'b0;
    chk("nrm_c1_state", 32'(state), 1);
    chk("nrm_c1_door", 32'(door), 1);
    chk("nrm_c1_me", 32'(motion_enable), 0);
    step(3);
    chk("nrm_c4_state", 32'(state), 1);
    step(1);
    chk("nrm_c5_state", 32'(state), 2);
    step(7);
    chk("nrm_c12_state", 32'(state), 2);
    step(1);
    chk("nrm_c13_state", 32'(state), 3);
    step(3);
    chk("nrm_c16_state", 32'(state), 3);
    step(1);
    chk("nrm_c17_state", 32'(state), 0);
    chk("nrm_c17_me", 32'(motion_enable), 1);
    chk("nrm_c17_door", 32'(door), 0);

    // overload
    arrive_to_open();
    chk("ovl_open", 32'(state), 2);
    weight_limit_exceeded = 1'b1;
    step(2);
    chk("ovl_sync_lat", 32'(state), 2);
    step(1);
    chk("ovl_state", 32'(state), 4);
    chk("ovl_alarm", 32'(overload_alarm), 1);
    step(100);
    chk("ovl_hold_state", 32'(state), 4);
    chk("ovl_hold_door", 32'(door), 1);
    close_request = 1'b1;
    arrived       = 1'b1;
    open_request  = 1'b1;
    step(3);
    close_request = 1'b0;
    arrived       = 1'b0;
    open_request  = 1'b0;
    chk("ovl_btn_ignored", 32'(state), 4);
    load_clear = 1'b1;
    step(1);
    load_clear = 1'b0;
    chk("clr_state", 32'(state), 5);
    chk("clr_wfr", 32'(weight_flip_reset), 1);
    chk("clr_alarm", 32'(overload_alarm), 1);
    step(2);
    chk("clr_wle_held", 32'(state), 5);
    weight_limit_exceeded = 1'b0;
    n = 0;
    while (state != 3'd2 && n < 5) begin
      step(1);
      n++;
    end
    chk("clr_to_open", 32'(state), 2);
    chk("clr_wfr_off", 32'(weight_flip_reset), 0);
    n = 1;
    step(1);
    while (state == 3'd2 && n < 20) begin
      n++;
      step(1);
    end
    chk("clr_open_len", 32'(n), 8);
    chk("clr_then_closing", 32'(state), 3);
    step(4);
    chk("clr_closed", 32'(state), 0);

    // reopen from CLOSING, then open+close held in OPEN
    arrive_to_open();
    step(8);
    chk("rop_closing1", 32'(state), 3);
    step(1);
    open_request = 1'b1;
    step(1);
    open_request = 1'b0;
    chk("rop_opening", 32'(state), 1);
    step(3);
    chk("rop_opening4", 32'(state), 1);
    step(1);
    chk("rop_open", 32'(state), 2);
    open_request  = 1'b1;
    close_request = 1'b1;
    step(3);
    open_request  = 1'b0;
    close_request = 1'b0;
    chk("both_stay_open", 32'(state), 2);
    step(7);
    chk("both_reload_end", 32'(state), 2);
    step(1);
    chk("both_then_close", 32'(state), 3);
    step(4);
    chk("rop_closed", 32'(state), 0);
    close_request = 1'b1;
    step(2);
    close_request = 1'b0;
    chk("closed_close_ign", 32'(state), 0);

    // close button in first OPEN cycle
    arrive_to_open();
    close_request = 1'b1;
    step(1);
    close_request = 1'b0;
    chk("btn_close", 32'(state), 3);
    step(4);
    chk("btn_closed", 32'(state), 0);

    // async reset during CLEARING
    arrive_to_open();
    weight_limit_exceeded = 1'b1;
    step(3);
    chk("mid_ovl", 32'(state), 4);
    load_clear = 1'b1;
    step(1);
    chk("mid_clr", 32'(state), 5);
    #2;
    button_reset = 1'b1;
    #1;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_wfr", 32'(weight_flip_reset), 0);
    chk("mid_rst_alarm", 32'(overload_alarm), 0);
    chk("mid_rst_me", 32'(motion_enable), 1);
    load_clear            = 1'b0;
    weight_limit_exceeded = 1'b0;
    @(negedge clk);
    button_reset = 1'b0;
    step(3);
    chk("post_rst_idle", 32'(state), 0);

`ifdef DOOR_OBSTRUCTION_EN
    arrive_to_open();
    step(8);
    chk("obs_closing", 32'(state), 3);
    obstruction = 1'b1;
    step(1);
    obstruction = 1'b0;
    chk("obs_reopen", 32'(state), 1);
    step(4);
    chk("obs_open", 32'(state), 2);
    step(7);
    obstruction = 1'b1;
    step(1);
    obstruction = 1'b0;
    chk("obs_hold_open", 32'(state), 2);
    step(7);
    chk("obs_reload_end", 32'(state), 2);
    step(1);
    chk("obs_closing2", 32'(state), 3);
    step(4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
